// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs field-level descriptions into machine words and
// writes legal ones to consecutive instruction-memory addresses; illegal ones set a sticky error.
module inst_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [31:0]       in_imm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    K_LOAD    = 3'd0,
    K_STORE   = 3'd1,
    K_OP      = 3'd2,
    K_BRANCH  = 3'd3,
    K_OPIMM   = 3'd4,
    K_JAL     = 3'd5,
    K_JALR    = 3'd6,
    K_ILLEGAL = 3'd7
  } kind_e;

  typedef enum logic [1:0] {
    E_NONE  = 2'd0,
    E_FIELD = 2'd1,
    E_RANGE = 2'd2,
    E_ALIGN = 2'd3
  } err_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(DEPTH);

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic [ADDR_W:0]   count_q;
  logic              err_q;
  err_e              err_code_q;

  kind_e             kind;
  logic signed [31:0] imm_s;
  logic              i_ok, b_ok, j_ok;
  logic              bad_field, bad_range, bad_align;
  logic [31:0]       word_d;
  err_e              err_d;
  logic              fire;

  assign kind  = kind_e'(in_kind);
  assign imm_s = $signed(in_imm);
  assign i_ok  = (imm_s >= -32'sd2048)    && (imm_s <= 32'sd2047);
  assign b_ok  = (imm_s >= -32'sd4096)    && (imm_s <= 32'sd4094);
  assign j_ok  = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574);

  always_comb begin
    word_d    = '0;
    bad_field = 1'b0;
    bad_range = 1'b0;
    bad_align = 1'b0;
    unique case (kind)
      K_LOAD: begin
        word_d    = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
        bad_field = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111);
        bad_range = !i_ok;
      end
      K_STORE: begin
        word_d    = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
        bad_field = (in_funct3 >= 3'b011);
        bad_range = !i_ok;
      end
      K_OP: begin
        word_d    = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
        bad_field = in_alt && (in_funct3 != 3'b000) && (in_funct3 != 3'b101);
      end
      K_BRANCH: begin
        word_d    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], OPC_BRANCH};
        bad_field = (in_funct3 == 3'b010) || (in_funct3 == 3'b011);
        bad_align = in_imm[0];
        bad_range = !b_ok;
      end
      K_OPIMM: begin
        // Shifts carry funct7 in the upper immediate bits and only a 5-bit shamt.
        if ((in_funct3 == 3'b001) || (in_funct3 == 3'b101)) begin
          word_d    = {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
          bad_field = in_alt && (in_funct3 == 3'b001);
          bad_range = |in_imm[31:5];
        end else begin
          word_d    = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
          bad_range = !i_ok;
        end
      end
      K_JAL: begin
        word_d    = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
        bad_align = in_imm[0];
        bad_range = !j_ok;
      end
      K_JALR: begin
        word_d    = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_JALR};
        bad_field = (in_funct3 != 3'b000);
        bad_range = !i_ok;
      end
      K_ILLEGAL: begin
        bad_field = 1'b1;
      end
      default: begin
        bad_field = 1'b1;
      end
    endcase
  end

  always_comb begin
    if (bad_field)      err_d = E_FIELD;
    else if (bad_align) err_d = E_ALIGN;
    else if (bad_range) err_d = E_RANGE;
    else                err_d = E_NONE;
  end

  assign full     = (count_q == LIMIT);
  assign in_ready = ~full & ~start;
  assign fire     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= E_NONE;
    end else begin
      wr_en_q <= 1'b0;
      if (start) begin
        count_q    <= '0;
        err_q      <= 1'b0;
        err_code_q <= E_NONE;
      end else if (fire) begin
        if (err_d == E_NONE) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= BASE + count_q[ADDR_W-1:0];
          wr_data_q <= word_d;
          count_q   <= count_q + 1'b1;
        end else begin
          err_q <= 1'b1;
          if (!err_q) err_code_q <= err_d;
        end
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign count    = count_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder (DEPTH=4): encodings, handshake, errors, full, start, reset.
module tb_inst_encoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic        in_alt;
  logic [31:0] in_imm;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [10:0] count;
  logic        full;
  logic        err;
  logic [1:0]  err_code;

  int unsigned n_total;
  int unsigned n_pass;
  int unsigned n_fail;

  inst_encoder #(.ADDR_W(10), .DEPTH(4), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .count(count),
    .full(full), .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                       input logic [31:0] imm);
    in_valid  = 1'b1;
    in_kind   = k;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_alt    = alt;
    in_imm    = imm;
  endtask

  task automatic new_session();
    in_valid = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic err_case(input string tag, input logic [2:0] k, input logic [2:0] f3,
                          input logic alt, input logic [31:0] imm, input logic [1:0] code);
    new_session();
    drive(k, 5'd1, 5'd2, 5'd3, f3, alt, imm);
    tick();
    in_valid = 1'b0;
    chk({tag, ".wr_en"}, 64'(wr_en), 64'd0);
    chk({tag, ".err"}, 64'(err), 64'd1);
    chk({tag, ".code"}, 64'(err_code), 64'(code));
  endtask

  task automatic ok_case(input string tag, input logic [2:0] k, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic alt, input logic [31:0] imm, input logic [31:0] word);
    new_session();
    drive(k, rd, rs1, rs2, f3, alt, imm);
    tick();
    in_valid = 1'b0;
    chk({tag, ".wr_en"}, 64'(wr_en), 64'd1);
    chk({tag, ".data"}, 64'(wr_data), 64'(word));
    chk({tag, ".err"}, 64'(err), 64'd0);
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_alt = 1'b0; in_imm = '0;
    tick();
    tick();
    chk("rst.wr_en", 64'(wr_en), 64'd0);
    chk("rst.wr_addr", 64'(wr_addr), 64'd0);
    chk("rst.wr_data", 64'(wr_data), 64'd0);
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.full", 64'(full), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    chk("rst.err_code", 64'(err_code), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // addi x1,x0,5 then sub x3,x1,x2 back-to-back
    drive(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
    tick();
    drive(3'd2, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0);
    chk("addi.wr_en", 64'(wr_en), 64'd1);
    chk("addi.addr", 64'(wr_addr), 64'd0);
    chk("addi.data", 64'(wr_data), 64'h00500093);
    chk("addi.count", 64'(count), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("sub.wr_en", 64'(wr_en), 64'd1);
    chk("sub.addr", 64'(wr_addr), 64'd1);
    chk("sub.data", 64'(wr_data), 64'h402081B3);
    chk("sub.count", 64'(count), 64'd2);
    tick();
    chk("idle.wr_en", 64'(wr_en), 64'd0);
    chk("idle.addr_hold", 64'(wr_addr), 64'd1);
    chk("idle.data_hold", 64'(wr_data), 64'h402081B3);
    new_session();
    chk("start.count", 64'(count), 64'd0);

    // Format coverage, fills DEPTH=4
    drive(3'd1, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd8);
    tick();
    drive(3'd3, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, -32'sd4);
    chk("sw.addr", 64'(wr_addr), 64'd0);
    chk("sw.data", 64'(wr_data), 64'h0020A423);
    tick();
    drive(3'd5, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048);
    chk("beq.wr_en", 64'(wr_en), 64'd1);
    chk("beq.addr", 64'(wr_addr), 64'd1);
    chk("beq.data", 64'(wr_data), 64'hFE208EE3);
    tick();
    drive(3'd4, 5'd5, 5'd5, 5'd0, 3'b101, 1'b1, 32'd3);
    chk("jal.addr", 64'(wr_addr), 64'd2);
    chk("jal.data", 64'(wr_data), 64'h001000EF);
    tick();
    drive(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
    chk("srai.addr", 64'(wr_addr), 64'd3);
    chk("srai.data", 64'(wr_data), 64'h4032D293);
    chk("srai.count", 64'(count), 64'd4);
    chk("full.full", 64'(full), 64'd1);
    chk("full.in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("held.wr_en", 64'(wr_en), 64'd0);
    chk("held.count", 64'(count), 64'd4);
    tick();
    chk("held2.count", 64'(count), 64'd4);
    start = 1'b1;
    #1;
    chk("startcyc.in_ready", 64'(in_ready), 64'd0);
    tick();
    start = 1'b0;
    #1;
    chk("restart.count", 64'(count), 64'd0);
    chk("restart.full", 64'(full), 64'd0);
    chk("restart.wr_en", 64'(wr_en), 64'd0);
    chk("restart.in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("fifth.wr_en", 64'(wr_en), 64'd1);
    chk("fifth.addr", 64'(wr_addr), 64'd0);
    chk("fifth.data", 64'(wr_data), 64'h00500093);
    chk("fifth.count", 64'(count), 64'd1);

    // Sticky error: first code kept, later legal write at unchanged address
    drive(3'd3, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd3);
    tick();
    chk("misal.wr_en", 64'(wr_en), 64'd0);
    chk("misal.err", 64'(err), 64'd1);
    chk("misal.code", 64'(err_code), 64'd3);
    chk("misal.count", 64'(count), 64'd1);
    drive(3'd0, 5'd1, 5'd0, 5'd0, 3'b010, 1'b0, 32'd4096);
    tick();
    chk("range2.code", 64'(err_code), 64'd3);
    chk("range2.wr_en", 64'(wr_en), 64'd0);
    chk("range2.count", 64'(count), 64'd1);
    drive(3'd4, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd7);
    tick();
    chk("after_err.wr_en", 64'(wr_en), 64'd1);
    chk("after_err.addr", 64'(wr_addr), 64'd1);
    chk("after_err.data", 64'(wr_data), 64'h00700113);
    chk("after_err.err", 64'(err), 64'd1);
    drive(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
    start = 1'b1;
    #1;
    chk("startvalid.in_ready", 64'(in_ready), 64'd0);
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    chk("startvalid.count", 64'(count), 64'd0);
    chk("startvalid.err", 64'(err), 64'd0);
    chk("startvalid.code", 64'(err_code), 64'd0);
    chk("startvalid.wr_en", 64'(wr_en), 64'd0);

    // Error classes, priorities and range edges
    err_case("kind7",       3'd7, 3'b000, 1'b0, 32'd0,        2'd1);
    err_case("ld_f3",       3'd0, 3'b011, 1'b0, 32'd0,        2'd1);
    err_case("ld_2048",     3'd0, 3'b010, 1'b0, 32'd2048,     2'd2);
    err_case("ld_m2049",    3'd0, 3'b010, 1'b0, -32'sd2049,   2'd2);
    err_case("st_f3",       3'd1, 3'b011, 1'b0, 32'd0,        2'd1);
    err_case("br_f3_mis",   3'd3, 3'b010, 1'b0, 32'd3,        2'd1);
    err_case("br_4095",     3'd3, 3'b000, 1'b0, 32'd4095,     2'd3);
    err_case("br_4096",     3'd3, 3'b000, 1'b0, 32'd4096,     2'd2);
    err_case("jal_2p20",    3'd5, 3'b000, 1'b0, 32'd1048576,  2'd2);
    err_case("jalr_f3",     3'd6, 3'b001, 1'b0, 32'd0,        2'd1);
    err_case("op_alt_f3",   3'd2, 3'b001, 1'b1, 32'd0,        2'd1);
    err_case("slli_alt",    3'd4, 3'b001, 1'b1, 32'd1,        2'd1);
    err_case("srli_32",     3'd4, 3'b101, 1'b0, 32'd32,       2'd2);

    ok_case("lw_m2048",  3'd0, 5'd1, 5'd2, 5'd0, 3'b010, 1'b0, -32'sd2048,   32'h80012083);
    ok_case("bne_4094",  3'd3, 5'd0, 5'd1, 5'd2, 3'b001, 1'b0, 32'd4094,     32'h7E209FE3);
    ok_case("jal_max",   3'd5, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1048574,  32'h7FFFF06F);
    ok_case("slli_31",   3'd4, 5'd1, 5'd1, 5'd0, 3'b001, 1'b0, 32'd31,       32'h01F09093);
    ok_case("jalr_m1",   3'd6, 5'd0, 5'd1, 5'd0, 3'b000, 1'b0, -32'sd1,      32'hFFF08067);

    // Reset in the cycle after a transfer drops the pending write
    new_session();
    drive(3'd7, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0);
    tick();
    drive(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
    tick();
    in_valid = 1'b0;
    chk("prerst.wr_en", 64'(wr_en), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst.wr_en", 64'(wr_en), 64'd0);
    chk("midrst.addr", 64'(wr_addr), 64'd0);
    chk("midrst.data", 64'(wr_data), 64'd0);
    chk("midrst.count", 64'(count), 64'd0);
    chk("midrst.err", 64'(err), 64'd0);
    chk("midrst.code", 64'(err_code), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("postrst.in_ready", 64'(in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
